hermes_switch_control: RTL

//  Per-router switch allocator for the Hermes mesh. The five input buffers (E,W,N,S,LOCAL) each

---
 rtl/hermes_switch_control.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/hermes_switch_control.sv
// hermes_switch_control: round-robin XY switch allocator; ack 2 cycles after request sampling, tables 1 cycle later.
// Blocked requests stay held by the input and retry; HERMES_SC_CONFLICT_CNT_EN adds a saturating reject counter.
module hermes_switch_control #(
   parameter logic [15:0] ADDRESS   = 16'h0000,
   parameter int          FLIT_SIZE = 32,
   parameter int          NPORT     = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NPORT-1:0]           req_i,
   input  logic [NPORT*FLIT_SIZE-1:0] header_i,
   input  logic [NPORT-1:0]           eop_i,
   output logic [NPORT-1:0]           ack_o,
   output logic [NPORT-1:0]           in_valid_o,
   output logic [NPORT*3-1:0]         in_sel_o,
   output logic [NPORT-1:0]           out_valid_o,
   output logic [NPORT*3-1:0]         out_sel_o,
   output logic [15:0]                conflict_cnt_o
);

   localparam logic [2:0] EAST      = 3'd0;
   localparam logic [2:0] WEST      = 3'd1;
   localparam logic [2:0] NORTH     = 3'd2;
   localparam logic [2:0] SOUTH     = 3'd3;
   localparam logic [2:0] LOCAL     = 3'd4;
   localparam logic [2:0] LAST_PORT = 3'(NPORT - 1);
   localparam logic [7:0] MY_X      = ADDRESS[15:8];
   localparam logic [7:0] MY_Y      = ADDRESS[7:0];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       dst_q, dst_d;
   logic [NPORT-1:0] in_valid_q, in_valid_d;
   logic [NPORT-1:0] out_valid_q, out_valid_d;
   logic [2:0]       in_sel_q  [NPORT];
   logic [2:0]       in_sel_d  [NPORT];
   logic [2:0]       out_sel_q [NPORT];
   logic [2:0]       out_sel_d [NPORT];

   logic [NPORT-1:0] eligible;
   logic             found;
   logic [2:0]       pick;
   logic [15:0]      hdr_tgt [NPORT];
   logic [15:0]      target;
   logic [2:0]       route_dst;
   logic             reject;
   logic             unused_hdr;

   function automatic logic [2:0] wrap_inc(input logic [2:0] v);
      return (v == LAST_PORT) ? 3'd0 : v + 3'd1;
   endfunction

   assign eligible   = req_i & ~in_valid_q;
   assign unused_hdr = ^header_i;

   // Round-robin search starting at ptr_q, wrapping modulo NPORT.
   always_comb begin : pick_blk
      logic [3:0] idx;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < NPORT; i++) begin
         idx = {1'b0, ptr_q} + 4'(i);
         if (idx >= 4'(NPORT)) begin
            idx = idx - 4'(NPORT);
         end
         if (!found && eligible[idx[2:0]]) begin
            found = 1'b1;
            pick  = idx[2:0];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         hdr_tgt[p] = header_i[p*FLIT_SIZE +: 16];
      end
   end

   assign target = hdr_tgt[sel_q];

   // XY order: resolve the X offset completely before moving in Y.
   always_comb begin
      if (target[15:8] > MY_X) begin
         route_dst = EAST;
      end else if (target[15:8] < MY_X) begin
         route_dst = WEST;
      end else if (target[7:0] > MY_Y) begin
         route_dst = NORTH;
      end else if (target[7:0] < MY_Y) begin
         route_dst = SOUTH;
      end else begin
         route_dst = LOCAL;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      dst_d       = dst_q;
      in_valid_d  = in_valid_q;
      out_valid_d = out_valid_q;
      in_sel_d    = in_sel_q;
      out_sel_d   = out_sel_q;
      ack_o       = '0;
      reject      = 1'b0;

      for (int p = 0; p < NPORT; p++) begin
         if (eop_i[p] && in_valid_q[p]) begin
            in_valid_d[p]               = 1'b0;
            out_valid_d[in_sel_q[p]]    = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               state_d = ROUTE;
            end
         end
         ROUTE: begin
            dst_d = route_dst;
            // Busy check uses the pre-release table; a same-cycle release is seen next round.
            if (!out_valid_q[route_dst]) begin
               state_d = GRANT;
            end else begin
               reject  = 1'b1;
               ptr_d   = wrap_inc(sel_q);
               state_d = IDLE;
            end
         end
         GRANT: begin
            ack_o[sel_q]       = 1'b1;
            out_valid_d[dst_q] = 1'b1;
            out_sel_d[dst_q]   = sel_q;
            in_valid_d[sel_q]  = 1'b1;
            in_sel_d[sel_q]    = dst_q;
            ptr_d              = wrap_inc(sel_q);
            state_d            = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         ptr_q       <= '0;
         dst_q       <= '0;
         in_valid_q  <= '0;
         out_valid_q <= '0;
         in_sel_q    <= '{default: '0};
         out_sel_q   <= '{default: '0};
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         dst_q       <= dst_d;
         in_valid_q  <= in_valid_d;
         out_valid_q <= out_valid_d;
         in_sel_q    <= in_sel_d;
         out_sel_q   <= out_sel_d;
      end
   end

   always_comb begin
      in_sel_o  = '0;
      out_sel_o = '0;
      for (int p = 0; p < NPORT; p++) begin
         in_sel_o[p*3 +: 3]  = in_sel_q[p];
         out_sel_o[p*3 +: 3] = out_sel_q[p];
      end
   end

   assign in_valid_o  = in_valid_q;
   assign out_valid_o = out_valid_q;

`ifdef HERMES_SC_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (reject && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         conflict_cnt_q <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign conflict_cnt_o = conflict_cnt_q;
`else
   logic unused_reject;
   assign unused_reject  = reject;
   assign conflict_cnt_o = 16'h0000;
`endif

endmodule
